// File: rtl/axi4_slave_ram.sv
// axi4_slave_ram
//   AXI4 slave responder backed by an on-chip RAM. Accepts one write burst and
//   one read burst at a time on independent channels, stores full-width beats
//   with byte strobes and returns read bursts with rlast. FIXED and INCR bursts
//   are served; WRAP and reserved burst types get SLVERR for the whole burst.
//
//   Write FSM
//     state  | meaning
//     W_IDLE | awready high, waiting for a write address
//     W_DATA | wready high, storing beats until wlast
//     W_RESP | bvalid high with bid/bresp, waiting for bready
//   Read FSM
//     state   | meaning
//     R_IDLE  | arready high, waiting for a read address
//     R_FETCH | one-cycle synchronous RAM read of the current beat
//     R_DATA  | rvalid high with rdata/rresp/rlast held until rready
//
// Ports
//   s_axi_aclk, s_axi_areset          clock, synchronous active-high reset
//   s_axi_aw* / s_axi_awvalid/awready  write address channel (awsize ignored)
//   s_axi_w*  / s_axi_wvalid/wready    write data channel
//   s_axi_b*  / s_axi_bvalid/bready    write response channel
//   s_axi_ar* / s_axi_arvalid/arready  read address channel (arsize ignored)
//   s_axi_r*  / s_axi_rvalid/rready    read data channel
module axi4_slave_ram #(
  parameter int AXI_ADDR_WIDTH   = 32,
  parameter int AXI_DATA_WIDTH   = 512,
  parameter int AXI_STROBE_WIDTH = AXI_DATA_WIDTH >> 3,
  parameter int AXI_STROBE_LEN   = $clog2(AXI_STROBE_WIDTH),
  parameter int MEM_DEPTH        = 1024,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                        s_axi_aclk,
  input  logic                        s_axi_areset,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [15:0]                 s_axi_awid,
  input  logic [1:0]                  s_axi_awburst,
  input  logic [2:0]                  s_axi_awsize,
  input  logic [7:0]                  s_axi_awlen,
  input  logic                        s_axi_awvalid,
  output logic                        s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [AXI_STROBE_WIDTH-1:0] s_axi_wstrb,
  input  logic                        s_axi_wlast,
  input  logic                        s_axi_wvalid,
  output logic                        s_axi_wready,
  output logic [15:0]                 s_axi_bid,
  output logic [1:0]                  s_axi_bresp,
  output logic                        s_axi_bvalid,
  input  logic                        s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [15:0]                 s_axi_arid,
  input  logic [1:0]                  s_axi_arburst,
  input  logic [2:0]                  s_axi_arsize,
  input  logic [7:0]                  s_axi_arlen,
  input  logic                        s_axi_arvalid,
  output logic                        s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [15:0]                 s_axi_rid,
  output logic [1:0]                  s_axi_rresp,
  output logic                        s_axi_rlast,
  output logic                        s_axi_rvalid,
  input  logic                        s_axi_rready
);

  localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [AXI_ADDR_WIDTH-1:0] DEPTH_A = AXI_ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [AXI_ADDR_WIDTH-1:0] ONE_A   = AXI_ADDR_WIDTH'(1);
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

  logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic unused_size;
  assign unused_size = ^{s_axi_awsize, s_axi_arsize};

  // Offset from BASE_ADDR with the borrow kept as the "below base" flag.
  logic [AXI_ADDR_WIDTH:0] aw_diff, ar_diff;
  assign aw_diff = {1'b0, s_axi_awaddr} - {1'b0, BASE_ADDR};
  assign ar_diff = {1'b0, s_axi_araddr} - {1'b0, BASE_ADDR};

  // ---------------------------------------------------------------- write
  w_state_t                  w_state;
  logic [AXI_ADDR_WIDTH-1:0] w_idx;
  logic                      w_below;
  logic [1:0]                w_burst;
  logic [7:0]                w_len;
  logic [15:0]               w_id;
  logic [8:0]                w_cnt;   // beats accepted so far, saturating
  logic                      w_err;

  logic w_fire, w_in_burst, w_beat_oor, w_beat_err, w_cnt_bad, ram_we;
  assign w_fire     = (w_state == W_DATA) && s_axi_wvalid && s_axi_wready;
  assign w_in_burst = w_cnt <= {1'b0, w_len};
  assign w_beat_oor = w_below || (w_idx >= DEPTH_A);
  assign w_beat_err = w_fire && w_in_burst && w_beat_oor;
  assign w_cnt_bad  = w_cnt != {1'b0, w_len};
  // Beats past len+1 are dropped; WRAP/reserved bursts never touch the RAM.
  assign ram_we     = w_fire && w_in_burst && !w_burst[1] && !w_beat_oor && !s_axi_areset;

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      s_axi_bid     <= '0;
      w_idx         <= '0;
      w_below       <= 1'b0;
      w_burst       <= '0;
      w_len         <= '0;
      w_id          <= '0;
      w_cnt         <= '0;
      w_err         <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          s_axi_awready <= 1'b1;
          if (s_axi_awready && s_axi_awvalid) begin
            w_idx         <= aw_diff[AXI_ADDR_WIDTH-1:0] >> AXI_STROBE_LEN;
            w_below       <= aw_diff[AXI_ADDR_WIDTH];
            w_burst       <= s_axi_awburst;
            w_len         <= s_axi_awlen;
            w_id          <= s_axi_awid;
            w_cnt         <= '0;
            w_err         <= s_axi_awburst[1];
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            w_state       <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            if (w_cnt != 9'h1FF) w_cnt <= w_cnt + 9'd1;
            if (w_in_burst && w_burst == BURST_INCR) w_idx <= w_idx + ONE_A;
            if (w_beat_err) w_err <= 1'b1;
            if (s_axi_wlast) begin
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bid    <= w_id;
              s_axi_bresp  <= (w_err || w_beat_err || w_cnt_bad) ? RESP_SLVERR : RESP_OKAY;
              w_state      <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (ram_we) begin
      for (int i = 0; i < AXI_STROBE_WIDTH; i++) begin
        if (s_axi_wstrb[i]) mem[w_idx[MEM_AW-1:0]][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
      end
    end
  end

  // ----------------------------------------------------------------- read
  r_state_t                  r_state;
  logic [AXI_ADDR_WIDTH-1:0] r_idx;
  logic                      r_below;
  logic [1:0]                r_burst;
  logic [7:0]                r_len;
  logic [7:0]                r_cnt;
  logic [15:0]               r_id;

  logic r_beat_err;
  assign r_beat_err = r_burst[1] || r_below || (r_idx >= DEPTH_A);

  // The RAM read here sees the pre-edge contents, so a same-cycle write to
  // the same word is returned as old data.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rid     <= '0;
      r_idx         <= '0;
      r_below       <= 1'b0;
      r_burst       <= '0;
      r_len         <= '0;
      r_cnt         <= '0;
      r_id          <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          s_axi_arready <= 1'b1;
          if (s_axi_arready && s_axi_arvalid) begin
            r_idx         <= ar_diff[AXI_ADDR_WIDTH-1:0] >> AXI_STROBE_LEN;
            r_below       <= ar_diff[AXI_ADDR_WIDTH];
            r_burst       <= s_axi_arburst;
            r_len         <= s_axi_arlen;
            r_id          <= s_axi_arid;
            r_cnt         <= '0;
            s_axi_arready <= 1'b0;
            r_state       <= R_FETCH;
          end
        end
        R_FETCH: begin
          s_axi_rvalid <= 1'b1;
          s_axi_rid    <= r_id;
          s_axi_rlast  <= (r_cnt == r_len);
          if (r_beat_err) begin
            s_axi_rdata <= '0;
            s_axi_rresp <= RESP_SLVERR;
          end else begin
            s_axi_rdata <= mem[r_idx[MEM_AW-1:0]];
            s_axi_rresp <= RESP_OKAY;
          end
          r_state <= R_DATA;
        end
        R_DATA: begin
          if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rlast  <= 1'b0;
            if (s_axi_rlast) begin
              s_axi_arready <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              r_cnt <= r_cnt + 8'd1;
              if (r_burst == BURST_INCR) r_idx <= r_idx + ONE_A;
              r_state <= R_FETCH;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule
